// File: rtl/decode_control.sv
// decode_control: fetch/execute sequencer sitting directly behind the fetch
// register. It walks IDLE -> FETCH -> EXEC (-> JADDR) and decodes every
// datapath enable combinationally from the current state, the latched opcode
// and the jump condition captured in EXEC.

package decode_control_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_JADDR = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  // Opcode map (upper nibble of the fetched program byte).
  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LIT   = 4'h1,
    OP_IN    = 4'h2,
    OP_OUT   = 4'h3,
    OP_ADDI  = 4'h4,
    OP_SUBI  = 4'h5,
    OP_NANDI = 4'h6,
    OP_CMPI  = 4'h7,
    OP_JMP   = 4'h8,
    OP_JC    = 4'h9,
    OP_JNC   = 4'hA,
    OP_JZ    = 4'hB,
    OP_JNZ   = 4'hC,
    OP_RSV_D = 4'hD,
    OP_RSV_E = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  // ALU function select.
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_NAND = 3'b011;

  // Bundle of single-cycle datapath controls (address is handled separately
  // because its width is a parameter).
  typedef struct packed {
    logic       fetch_en;
    logic       pc_inc;
    logic       pc_load;
    logic       acc_en;
    logic       flags_en;
    logic       out_en;
    logic [2:0] alu_sel;
    logic       oprnd_oe;
    logic       in_oe;
    logic       alu_oe;
    logic       phase;
    logic       halted;
  } ctrl_t;

endpackage

module decode_control
  import decode_control_pkg::*;
#(
  parameter int         ADDR_W   = 12,
  parameter logic [3:0] OPC_HALT = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [3:0]        instr,
  input  logic [3:0]        oprnd,
  input  logic [7:0]        program_byte,
  input  logic              c_flag,
  input  logic              z_flag,
  output logic              fetch_en,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] address,
  output logic              acc_en,
  output logic              flags_en,
  output logic              out_en,
  output logic [2:0]        alu_sel,
  output logic              oprnd_oe,
  output logic              in_oe,
  output logic              alu_oe,
  output logic              phase,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [3:0]        hi_q, hi_d;      // high nibble of the jump target
  logic              take_q, take_d;  // jump decision frozen at EXEC
  ctrl_t             ctrl;
  logic [ADDR_W-1:0] address_c;

  // True for the five conditional/unconditional jump opcodes.
  function automatic logic is_jump(input logic [3:0] op);
    return opcode_e'(op) inside {OP_JMP, OP_JC, OP_JNC, OP_JZ, OP_JNZ};
  endfunction

  // Jump condition evaluated against the flags visible during EXEC.
  function automatic logic jump_cond(input logic [3:0] op,
                                     input logic       c,
                                     input logic       z);
    logic taken;
    taken = 1'b0;
    case (opcode_e'(op))
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = c;
      OP_JNC:  taken = ~c;
      OP_JZ:   taken = z;
      OP_JNZ:  taken = ~z;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Next-state and jump-latch logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned and infer a latch.
    state_d = state_q;
    hi_d    = hi_q;
    take_d  = take_q;
    case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (instr == OPC_HALT) begin
          state_d = ST_HALT;
        end else if (is_jump(instr)) begin
          hi_d    = oprnd;
          take_d  = jump_cond(instr, c_flag, z_flag);
          state_d = ST_JADDR;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_JADDR: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;  // only reset leaves HALT; go is ignored
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and jump-latch registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q <= ST_IDLE;
      hi_q    <= 4'h0;
      take_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      take_q  <= take_d;
    end
  end

  // Output decode: purely from state, opcode and the latched jump decision,
  // so asserting reset drops every enable in the same instant.
  always_comb begin
    ctrl      = '0;
    address_c = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.fetch_en = 1'b1;
        ctrl.pc_inc   = 1'b1;
      end
      ST_EXEC: begin
        ctrl.phase = 1'b1;
        if (instr != OPC_HALT) begin
          case (opcode_e'(instr))
            OP_LIT: begin
              ctrl.oprnd_oe = 1'b1;
              ctrl.alu_sel  = ALU_PASS;
              ctrl.alu_oe   = 1'b1;
              ctrl.acc_en   = 1'b1;
            end
            OP_IN: begin
              ctrl.in_oe   = 1'b1;
              ctrl.alu_sel = ALU_PASS;
              ctrl.alu_oe  = 1'b1;
              ctrl.acc_en  = 1'b1;
            end
            OP_OUT: begin
              // Accumulator reaches the bus through the ALU pass path.
              ctrl.alu_sel = ALU_PASS;
              ctrl.alu_oe  = 1'b1;
              ctrl.out_en  = 1'b1;
            end
            OP_ADDI: begin
              ctrl.oprnd_oe = 1'b1;
              ctrl.alu_sel  = ALU_ADD;
              ctrl.alu_oe   = 1'b1;
              ctrl.acc_en   = 1'b1;
              ctrl.flags_en = 1'b1;
            end
            OP_SUBI: begin
              ctrl.oprnd_oe = 1'b1;
              ctrl.alu_sel  = ALU_SUB;
              ctrl.alu_oe   = 1'b1;
              ctrl.acc_en   = 1'b1;
              ctrl.flags_en = 1'b1;
            end
            OP_NANDI: begin
              ctrl.oprnd_oe = 1'b1;
              ctrl.alu_sel  = ALU_NAND;
              ctrl.alu_oe   = 1'b1;
              ctrl.acc_en   = 1'b1;
              ctrl.flags_en = 1'b1;
            end
            OP_CMPI: begin
              // Subtract for flags only; accumulator keeps its value.
              ctrl.oprnd_oe = 1'b1;
              ctrl.alu_sel  = ALU_SUB;
              ctrl.flags_en = 1'b1;
            end
            default: begin
              // NOP, jumps (decided here, acted on in JADDR), reserved D/E.
            end
          endcase
        end
      end
      ST_JADDR: begin
        ctrl.phase = 1'b1;
        if (take_q) begin
          ctrl.pc_load = 1'b1;
          address_c    = ADDR_W'({hi_q, program_byte});
        end else begin
          ctrl.pc_inc = 1'b1;  // step over the unused low address byte
        end
      end
      ST_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: begin
        // IDLE: everything low.
      end
    endcase
  end

  assign fetch_en = ctrl.fetch_en;
  assign pc_inc   = ctrl.pc_inc;
  assign pc_load  = ctrl.pc_load;
  assign address  = address_c;
  assign acc_en   = ctrl.acc_en;
  assign flags_en = ctrl.flags_en;
  assign out_en   = ctrl.out_en;
  assign alu_sel  = ctrl.alu_sel;
  assign oprnd_oe = ctrl.oprnd_oe;
  assign in_oe    = ctrl.in_oe;
  assign alu_oe   = ctrl.alu_oe;
  assign phase    = ctrl.phase;
  assign halted   = ctrl.halted;

endmodule

// File: tb/tb_decode_control.sv
// Bench for decode_control: scripts whole instructions (fetch, execute, jump
// address byte) and compares every cycle against an instruction-level model.
module tb_decode_control;

  typedef struct packed {
    logic        fetch_en;
    logic        pc_inc;
    logic        pc_load;
    logic [11:0] address;
    logic        acc_en;
    logic        flags_en;
    logic        out_en;
    logic [2:0]  alu_sel;
    logic        oprnd_oe;
    logic        in_oe;
    logic        alu_oe;
    logic        phase;
    logic        halted;
  } ov_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [3:0]  instr = 4'h0;
  logic [3:0]  oprnd = 4'h0;
  logic [7:0]  program_byte = 8'h00;
  logic        c_flag = 1'b0;
  logic        z_flag = 1'b0;
  logic        fetch_en, pc_inc, pc_load, acc_en, flags_en, out_en;
  logic [11:0] address;
  logic [2:0]  alu_sel;
  logic        oprnd_oe, in_oe, alu_oe, phase, halted;

  int   total = 0;
  int   bad = 0;
  logic chk_en = 1'b0;
  ov_t  exp_v = '0;
  ov_t  act_v;
  ov_t  obs[$];

  decode_control dut (
    .clk(clk), .reset(rst_n), .go(go), .instr(instr), .oprnd(oprnd),
    .program_byte(program_byte), .c_flag(c_flag), .z_flag(z_flag),
    .fetch_en(fetch_en), .pc_inc(pc_inc), .pc_load(pc_load), .address(address),
    .acc_en(acc_en), .flags_en(flags_en), .out_en(out_en), .alu_sel(alu_sel),
    .oprnd_oe(oprnd_oe), .in_oe(in_oe), .alu_oe(alu_oe), .phase(phase),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ov_t sample();
    ov_t v;
    v.fetch_en = fetch_en; v.pc_inc = pc_inc; v.pc_load = pc_load;
    v.address = address; v.acc_en = acc_en; v.flags_en = flags_en;
    v.out_en = out_en; v.alu_sel = alu_sel; v.oprnd_oe = oprnd_oe;
    v.in_oe = in_oe; v.alu_oe = alu_oe; v.phase = phase; v.halted = halted;
    return v;
  endfunction

  // ---------------- instruction-level model ----------------
  function automatic ov_t m_fetch();
    ov_t v = '0;
    v.fetch_en = 1'b1;
    v.pc_inc = 1'b1;
    return v;
  endfunction

  function automatic ov_t m_exec(input logic [3:0] op);
    ov_t v = '0;
    v.phase = 1'b1;
    case (op)
      4'h1: begin v.oprnd_oe = 1; v.alu_oe = 1; v.acc_en = 1; end
      4'h2: begin v.in_oe = 1; v.alu_oe = 1; v.acc_en = 1; end
      4'h3: begin v.alu_oe = 1; v.out_en = 1; end
      4'h4: begin v.oprnd_oe = 1; v.alu_sel = 3'd1; v.alu_oe = 1; v.acc_en = 1; v.flags_en = 1; end
      4'h5: begin v.oprnd_oe = 1; v.alu_sel = 3'd2; v.alu_oe = 1; v.acc_en = 1; v.flags_en = 1; end
      4'h6: begin v.oprnd_oe = 1; v.alu_sel = 3'd3; v.alu_oe = 1; v.acc_en = 1; v.flags_en = 1; end
      4'h7: begin v.oprnd_oe = 1; v.alu_sel = 3'd2; v.flags_en = 1; end
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic m_is_jump(input logic [3:0] op);
    return (op >= 4'h8) && (op <= 4'hC);
  endfunction

  function automatic logic m_taken(input logic [3:0] op, input logic c, input logic z);
    case (op)
      4'h8: return 1'b1;
      4'h9: return c;
      4'hA: return !c;
      4'hB: return z;
      4'hC: return !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ov_t m_jaddr(input logic take, input logic [3:0] hi, input logic [7:0] lo);
    ov_t v = '0;
    v.phase = 1'b1;
    if (take) begin
      v.pc_load = 1'b1;
      v.address = {hi, lo};
    end else begin
      v.pc_inc = 1'b1;
    end
    return v;
  endfunction

  function automatic ov_t m_halt();
    ov_t v = '0;
    v.halted = 1'b1;
    return v;
  endfunction

  // Single compare process: every negedge with checking enabled.
  always @(negedge clk) begin
    if (chk_en) begin
      act_v = sample();
      check("cycle", 32'(act_v), 32'(exp_v));
      obs.push_back(act_v);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic drive(input logic g, input logic [3:0] ins, input logic [3:0] opr,
                       input logic [7:0] pb, input logic c, input logic z, input ov_t e);
    @(posedge clk);
    #1;
    go = g; instr = ins; oprnd = opr; program_byte = pb;
    c_flag = c; z_flag = z; exp_v = e; chk_en = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    go = 1'b0;
    #1;
    check("reset_async_zero", 32'(sample()), 32'h0);
    @(posedge clk);
    #1;
    check("reset_hold_zero", 32'(sample()), 32'h0);
    rst_n = 1'b1;
  endtask

  // Reset, one idle cycle with go low, then raise go; FETCH follows.
  task automatic restart();
    do_reset();
    drive(1'b0, 4'($urandom), 4'($urandom), 8'($urandom), rb(), rb(), '0);
    drive(1'b1, 4'($urandom), 4'($urandom), 8'($urandom), rb(), rb(), '0);
    settle();
  endtask

  // One instruction: FETCH, EXEC and, for jumps, JADDR with the flags
  // inverted to show the decision was frozen in EXEC.
  task automatic run_instr(input logic [7:0] ib, input logic [7:0] lo,
                           input logic c, input logic z);
    logic [3:0] op;
    op = ib[7:4];
    drive(rb(), 4'($urandom), 4'($urandom), ib, rb(), rb(), m_fetch());
    drive(rb(), op, ib[3:0], lo, c, z, m_exec(op));
    if (m_is_jump(op))
      drive(rb(), op, ib[3:0], lo, !c, !z, m_jaddr(m_taken(op, c, z), ib[3:0], lo));
  endtask

  task automatic halt_run(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 4'($urandom), 4'($urandom), 8'($urandom), rb(), rb(), m_halt());
  endtask

  initial begin
    // Program LIT 5, ADDI 3, OUT.
    restart();
    obs.delete();
    run_instr(8'h15, 8'h00, 1'b0, 1'b0);
    run_instr(8'h43, 8'h00, 1'b0, 1'b0);
    run_instr(8'h30, 8'h00, 1'b0, 1'b0);
    settle();
    check("prog_phase_seq", 32'({obs[0].phase, obs[1].phase, obs[2].phase,
                                 obs[3].phase, obs[4].phase, obs[5].phase}), 32'b010101);
    check("lit_enables", 32'({obs[1].oprnd_oe, obs[1].alu_oe, obs[1].acc_en}), 32'b111);
    check("addi_alu_sel", 32'(obs[3].alu_sel), 32'b001);
    check("addi_acc_flags", 32'({obs[3].acc_en, obs[3].flags_en}), 32'b11);
    check("out_en_no_acc", 32'({obs[5].out_en, obs[5].acc_en}), 32'b10);

    // Reset in the middle of an ADDI execute cycle.
    drive(1'b0, 4'h0, 4'h0, 8'h42, 1'b0, 1'b0, m_fetch());
    drive(1'b0, 4'h4, 4'h2, 8'h00, 1'b0, 1'b0, m_exec(4'h4));
    restart();
    obs.delete();
    run_instr(8'h00, 8'h00, 1'b0, 1'b0);
    settle();
    check("restart_fetch", 32'({obs[0].fetch_en, obs[0].pc_inc, obs[0].phase}), 32'b110);

    // JMP 0xA:3C followed by a NOP.
    obs.delete();
    run_instr(8'h8A, 8'h3C, 1'b0, 1'b0);
    run_instr(8'h00, 8'h00, 1'b0, 1'b0);
    settle();
    check("jmp_address", 32'(obs[2].address), 32'hA3C);
    check("jmp_load_noinc", 32'({obs[2].pc_load, obs[2].pc_inc}), 32'b10);
    check("jmp_then_fetch", 32'(obs[3].fetch_en), 32'h1);

    // JZ not taken, then taken (z toggled during JADDR by run_instr).
    obs.delete();
    run_instr(8'hB5, 8'h77, 1'b1, 1'b0);
    run_instr(8'hB5, 8'h77, 1'b0, 1'b1);
    settle();
    check("jz_not_taken", 32'({obs[2].pc_inc, obs[2].pc_load}), 32'b10);
    check("jz_taken", 32'({obs[5].pc_inc, obs[5].pc_load}), 32'b01);
    check("jz_taken_addr", 32'(obs[5].address), 32'h577);

    // CMPI, reserved D and E.
    obs.delete();
    run_instr(8'h77, 8'h00, 1'b0, 1'b0);
    run_instr(8'hD3, 8'h00, 1'b0, 1'b0);
    run_instr(8'hE9, 8'h00, 1'b0, 1'b0);
    run_instr(8'h00, 8'h00, 1'b0, 1'b0);
    settle();
    check("cmpi_flags_only", 32'({obs[1].flags_en, obs[1].acc_en, obs[1].alu_sel}), 32'b10_010);
    check("rsvd_d_idle", 32'(obs[3]), 32'h2);
    check("rsvd_e_idle", 32'(obs[5]), 32'h2);
    check("rsvd_e_fetch", 32'(obs[6].fetch_en), 32'h1);

    // HALT: 20 cycles with go high, never fetch again.
    obs.delete();
    run_instr(8'hF0, 8'h00, 1'b0, 1'b0);
    halt_run(20);
    settle();
    check("halt_last", 32'(obs[21]), 32'h1);
    begin
      int fetches = 0;
      for (int i = 2; i < obs.size(); i++) fetches += int'(obs[i].fetch_en);
      check("halt_no_fetch", 32'(fetches), 32'h0);
    end
    restart();
    obs.delete();
    run_instr(8'h00, 8'h00, 1'b0, 1'b0);
    settle();
    check("halt_restart_fetch", 32'(obs[0].fetch_en), 32'h1);

    // Randomised instruction stream.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] ib;
      ib = 8'($urandom);
      run_instr(ib, 8'($urandom), rb(), rb());
      if (ib[7:4] == 4'hF) begin
        halt_run(5);
        restart();
      end
    end
    settle();
    obs.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
